// File: rtl/motor_cmd_pkg.sv
// Shared types for the motor command sequencer: drive directions, the uart_comm
// message word, the sequencer state and the direction-to-message encoder.
package motor_cmd_pkg;

    typedef enum logic [2:0] {
        STOP    = 3'd0,
        FWD     = 3'd1,
        RIGHT   = 3'd2,
        LEFT    = 3'd3,
        REV     = 3'd4,
        SPIN_L  = 3'd5,
        SPIN_R  = 3'd6,
        INVALID = 3'd7
    } dir_e;

    typedef struct packed {
        logic [2:0] sw_code;
        logic       neg_l;
        logic       neg_r;
    } uart_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Reverse and spin reuse the forward speed code with wheel negation flags.
    function automatic uart_cmd_t encode(input dir_e dir);
        uart_cmd_t c;
        c.sw_code = 3'b000;
        c.neg_l   = 1'b0;
        c.neg_r   = 1'b0;
        case (dir)
            FWD:    c.sw_code = 3'b001;
            RIGHT:  c.sw_code = 3'b010;
            LEFT:   c.sw_code = 3'b100;
            REV: begin
                c.sw_code = 3'b001;
                c.neg_l   = 1'b1;
                c.neg_r   = 1'b1;
            end
            SPIN_L: begin
                c.sw_code = 3'b001;
                c.neg_l   = 1'b1;
            end
            SPIN_R: begin
                c.sw_code = 3'b001;
                c.neg_r   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable saturating down-counter; done is high whenever the count is zero.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/motor_cmd_seq.sv
// Command sequencer feeding uart_comm: captures drive commands, holds each message
// across the handshake, spaces messages by a gap and re-sends on a heartbeat.
module motor_cmd_seq
    import motor_cmd_pkg::*;
#(
    parameter int HEARTBEAT_CYCLES = 10_000_000,
    parameter int GAP_CYCLES       = 50_000,
    parameter int CNT_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       cmd_dir,
    input  logic             cmd_stb,
    input  logic             estop,
    input  logic             ready,
    output logic [2:0]       sw_code,
    output logic             neg_l,
    output logic             neg_r,
    output logic             valid,
    output logic             cmd_err,
    output logic [CNT_W-1:0] sent_count,
    output state_e           state_dbg
);

    localparam int HB_W  = $clog2(HEARTBEAT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_e           state_q, state_d;
    dir_e             cur_cmd_q;
    uart_cmd_t        snap_q;
    logic             pending_q;
    logic             cmd_err_q;
    logic [CNT_W-1:0] sent_count_q;
    logic             stb_ok, xfer, enter_send, gap_done, hb_done;

    // Handshake: valid is high for the whole SEND state with a frozen message;
    // a transfer is any rising edge where valid && ready, and valid drops after it.
    assign stb_ok = cmd_stb && !estop && (cmd_dir != 3'd7);
    assign xfer   = (state_q == SEND) && ready;

    always_comb begin
        state_d    = state_q;
        enter_send = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d    = SEND;
                    enter_send = 1'b1;
                end
            end
            SEND: begin
                if (ready) state_d = GAP;
            end
            GAP: begin
                if (gap_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // The snapshot consumes the pending request; a capture on the same edge re-arms it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_cmd_q    <= STOP;
            pending_q    <= 1'b1;
            snap_q       <= '0;
            cmd_err_q    <= 1'b0;
            sent_count_q <= '0;
        end else begin
            if (estop)       cur_cmd_q <= STOP;
            else if (stb_ok) cur_cmd_q <= dir_e'(cmd_dir);

            if (estop || stb_ok)                   pending_q <= 1'b1;
            else if (enter_send)                   pending_q <= 1'b0;
            else if ((state_q == IDLE) && hb_done) pending_q <= 1'b1;

            if (enter_send) snap_q <= encode(cur_cmd_q);

            cmd_err_q <= cmd_stb && !estop && (cmd_dir == 3'd7);

            if (xfer) sent_count_q <= sent_count_q + 1'b1;
        end
    end

    // Gap timer holds GAP for exactly GAP_CYCLES cycles after a transfer.
    cycle_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer),
        .load_val (GAP_W'(GAP_CYCLES - 1)),
        .en       (state_q == GAP),
        .done     (gap_done)
    );

    // Heartbeat only runs while idle with nothing queued, and saturates at zero.
    cycle_timer #(.W(HB_W)) u_hb_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer),
        .load_val (HB_W'(HEARTBEAT_CYCLES)),
        .en       ((state_q == IDLE) && !pending_q),
        .done     (hb_done)
    );

    assign valid      = (state_q == SEND);
    assign sw_code    = snap_q.sw_code;
    assign neg_l      = snap_q.neg_l;
    assign neg_r      = snap_q.neg_r;
    assign cmd_err    = cmd_err_q;
    assign sent_count = sent_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_motor_cmd_seq.sv
// Randomized and directed bench for motor_cmd_seq against a cycle-level behavioural
// model of the command/heartbeat/gap rules and a transfer scoreboard.
module tb_motor_cmd_seq;

    localparam int HB  = 200;
    localparam int GAP = 10;
    localparam int CW  = 8;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [2:0]    cmd_dir = 3'd0;
    logic          cmd_stb = 1'b0;
    logic          estop   = 1'b0;
    logic          ready   = 1'b1;
    logic [2:0]    sw_code;
    logic          neg_l, neg_r, valid, cmd_err;
    logic [CW-1:0] sent_count;
    logic [1:0]    state_dbg;

    motor_cmd_seq #(
        .HEARTBEAT_CYCLES (HB),
        .GAP_CYCLES       (GAP),
        .CNT_W            (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_dir    (cmd_dir),
        .cmd_stb    (cmd_stb),
        .estop      (estop),
        .ready      (ready),
        .sw_code    (sw_code),
        .neg_l      (neg_l),
        .neg_r      (neg_r),
        .valid      (valid),
        .cmd_err    (cmd_err),
        .sent_count (sent_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // {sw_code, neg_l, neg_r} per direction 0..6
    logic [4:0] enc_tab [0:7];
    logic [4:0] exp_q [$];
    int         xfer_cyc [$];
    logic [4:0] last_xfer_msg;
    bit         wrap_seen;

    int m_phase;   // 0 waiting, 1 presenting a message, 2 spacing after a transfer
    int m_cur;     // latest accepted direction
    int m_snap;    // direction of the message being presented
    int m_gap_n;   // cycles spent spacing
    int m_hb;      // idle cycles with nothing queued since the last transfer
    int m_count;
    bit m_pend;
    bit m_err;

    task automatic model_reset();
        m_phase = 0; m_cur = 0; m_snap = 0; m_gap_n = 0; m_hb = 0;
        m_count = 0; m_pend = 1'b1; m_err = 1'b0;
    endtask

    task automatic model_step();
        bit ok;
        if (!rst) begin
            model_reset();
            return;
        end
        ok    = cmd_stb && (cmd_dir != 3'd7);
        m_err = cmd_stb && !estop && (cmd_dir == 3'd7);
        case (m_phase)
            0: begin
                if (m_pend) begin
                    m_phase = 1;
                    m_snap  = m_cur;
                    m_pend  = 1'b0;
                end else if (m_hb >= HB) begin
                    m_pend = 1'b1;
                end else begin
                    m_hb++;
                end
            end
            1: begin
                if (ready) begin
                    exp_q.push_back(enc_tab[m_snap]);
                    m_phase = 2;
                    m_gap_n = 0;
                    m_hb    = 0;
                    m_count = (m_count + 1) % (1 << CW);
                end
            end
            default: begin
                m_gap_n++;
                if (m_gap_n >= GAP) m_phase = 0;
            end
        endcase
        if (estop) begin
            m_cur  = 0;
            m_pend = 1'b1;
        end else if (ok) begin
            m_cur  = int'(cmd_dir);
            m_pend = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        logic          pre_x;
        logic [4:0]    pre_msg;
        logic [CW-1:0] prev_cnt;
        pre_x    = valid && ready;
        pre_msg  = {sw_code, neg_l, neg_r};
        prev_cnt = sent_count;
        @(posedge clk);
        model_step();
        cyc++;
        if (pre_x) begin
            xfer_cyc.push_back(cyc);
            last_xfer_msg = pre_msg;
            check("sb_has_entry", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("xfer_msg", pre_msg, exp_q.pop_front());
        end
        #1;
        if (prev_cnt == 8'hFF && sent_count == 8'h00) wrap_seen = 1'b1;
        check("valid", valid, m_phase == 1);
        if (m_phase == 1) check("msg", {sw_code, neg_l, neg_r}, enc_tab[m_snap]);
        check("cmd_err", cmd_err, m_err);
        check("sent_count", sent_count, m_count[CW-1:0]);
    endtask

    task automatic strobe(input logic [2:0] dir);
        cmd_stb = 1'b1;
        cmd_dir = dir;
        cycle();
        cmd_stb = 1'b0;
    endtask

    task automatic settle();
        cmd_stb = 1'b0;
        estop   = 1'b0;
        ready   = 1'b1;
        repeat (30) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CW-1:0] base;
        logic [CW-1:0] delta;
        int            d;

        enc_tab[0] = 5'b000_0_0;
        enc_tab[1] = 5'b001_0_0;
        enc_tab[2] = 5'b010_0_0;
        enc_tab[3] = 5'b100_0_0;
        enc_tab[4] = 5'b001_1_1;
        enc_tab[5] = 5'b001_1_0;
        enc_tab[6] = 5'b001_0_1;
        enc_tab[7] = 5'b000_0_0;
        wrap_seen     = 1'b0;
        last_xfer_msg = 5'h1F;
        model_reset();

        // reset state
        #1 rst = 1'b0;
        #1;
        check("rst_valid", valid, 1'b0);
        check("rst_sw_code", sw_code, 3'b000);
        check("rst_neg", {neg_l, neg_r}, 2'b00);
        check("rst_cmd_err", cmd_err, 1'b0);
        check("rst_count", sent_count, 0);
        repeat (3) cycle();
        rst = 1'b1;

        // first message after reset is STOP
        cycle();
        check("boot_stop_valid", valid, 1'b1);
        check("boot_stop_msg", {sw_code, neg_l, neg_r}, 5'b000_0_0);
        repeat (12) cycle();
        check("boot_count", sent_count, 1);

        // REV held by ready low, then released
        settle();
        ready = 1'b0;
        strobe(3'd4);
        repeat (32) cycle();
        check("rev_held_valid", valid, 1'b1);
        check("rev_held_msg", {sw_code, neg_l, neg_r}, 5'b001_1_1);
        base  = sent_count;
        ready = 1'b1;
        cycle();
        delta = sent_count - base;
        check("rev_count_step", delta, 1);
        check("rev_valid_drop", valid, 1'b0);

        // FWD then LEFT while STOP is being presented: only LEFT follows
        settle();
        ready = 1'b0;
        strobe(3'd0);
        cycle();
        strobe(3'd1);
        cycle();
        strobe(3'd3);
        base  = sent_count;
        ready = 1'b1;
        repeat (40) cycle();
        delta = sent_count - base;
        check("latest_wins_count", delta, 2);
        check("latest_wins_msg", last_xfer_msg, 5'b100_0_0);

        // estop during FWD: FWD completes, then STOP; FWD strobe under estop ignored
        settle();
        ready = 1'b0;
        strobe(3'd1);
        cycle();
        estop = 1'b1;
        cycle();
        strobe(3'd1);
        repeat (3) cycle();
        ready = 1'b1;
        cycle();
        check("estop_fwd_first", last_xfer_msg, 5'b001_0_0);
        cycle();
        estop = 1'b0;
        repeat (20) cycle();
        check("estop_then_stop", last_xfer_msg, 5'b000_0_0);
        repeat (30) cycle();
        check("estop_no_fwd", last_xfer_msg, 5'b000_0_0);

        // invalid code
        settle();
        base = sent_count;
        strobe(3'd7);
        check("err_pulse_hi", cmd_err, 1'b1);
        cycle();
        check("err_pulse_lo", cmd_err, 1'b0);
        check("err_no_valid", valid, 1'b0);
        repeat (15) cycle();
        check("err_count_same", sent_count, base);

        // latency from idle, then asynchronous reset mid-presentation
        settle();
        ready = 1'b0;
        strobe(3'd2);
        check("lat_edge1", valid, 1'b0);
        cycle();
        check("lat_edge2", valid, 1'b1);
        cycle();
        #3 rst = 1'b0;
        model_reset();
        #1;
        check("async_valid_drop", valid, 1'b0);
        check("async_count_clr", sent_count, 0);
        repeat (2) cycle();
        rst   = 1'b1;
        ready = 1'b1;
        repeat (30) cycle();
        check("post_reset_msg", last_xfer_msg, 5'b000_0_0);
        check("post_reset_count", sent_count, 1);

        // heartbeat with no strobes
        settle();
        xfer_cyc.delete();
        repeat (700) cycle();
        check("hb_enough_xfers", xfer_cyc.size() >= 3, 1'b1);
        for (int i = 1; i < xfer_cyc.size(); i++) begin
            d = xfer_cyc[i] - xfer_cyc[i-1];
            check("hb_period_211_to_213", (d >= 211) && (d <= 213), 1'b1);
        end

        // randomized traffic
        settle();
        for (int i = 0; i < 3000; i++) begin
            cmd_stb = ($urandom_range(0, 7) == 0);
            cmd_dir = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) estop = ~estop;
            ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // sent_count wrap under continuous estop traffic
        cmd_stb = 1'b0;
        estop   = 1'b1;
        ready   = 1'b1;
        repeat (3300) cycle();
        check("count_wrap_seen", wrap_seen, 1'b1);
        settle();
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
